button_debounce: RTL

- Upstream conditioning stage for the combinational gate blocks (logic_not and friends).
- Takes a raw, bouncing, asynchronous push-button/switch level, synchronises it to clk and debounces it.
- Delivers a clean level plus single-cycle edge pulses to downstream logic.

---
 rtl/button_debounce_pkg.sv | 39 +++
 rtl/button_debounce_sync_2ff.sv | 37 +++
 rtl/button_debounce.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/button_debounce_pkg.sv
// -----------------------------------------------------------------------------
// button_debounce_pkg
//
// Purpose:
//   Shared definitions for the push-button conditioning stage:
//     - bd_state_e : 2-bit debounce FSM state encoding
//     - bd_clog2   : ceiling log2 helper used to size the counters
//
// Ports: none (package).
// -----------------------------------------------------------------------------
package button_debounce_pkg;

  // The encoding is fixed so the state is easy to recognise in waveforms
  // and in any checker bound to the FSM.
  typedef enum logic [1:0] {
    IDLE_LOW   = 2'd0,
    CHECK_HIGH = 2'd1,
    IDLE_HIGH  = 2'd2,
    CHECK_LOW  = 2'd3
  } bd_state_e;

  // Ceiling log2 with a floor of 1, so a counter built from it never
  // collapses to zero width when the counted range is tiny.
  function automatic int bd_clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >>> 1;
    end
    if (result < 1) begin
      result = 1;
    end
    return result;
  endfunction

endpackage : button_debounce_pkg

// File: rtl/button_debounce_sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
//
// Purpose:
//   1-bit, two-flop synchroniser for an asynchronous level. The first flop
//   may go metastable; only the second flop's output is used downstream.
//   Both flops clear on a synchronous active-low reset.
//
// Ports:
//   clk_i   input  1  destination clock
//   rst_ni  input  1  synchronous, active-low reset
//   d_i     input  1  asynchronous level to be synchronised
//   q_o     output 1  synchronised level (two clk edges of latency)
// -----------------------------------------------------------------------------
module sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic s0_q;
  logic s1_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s0_q <= 1'b0;
      s1_q <= 1'b0;
    end else begin
      s0_q <= d_i;
      s1_q <= s0_q;
    end
  end

  assign q_o = s1_q;

endmodule : sync_2ff

// File: rtl/button_debounce.sv
// -----------------------------------------------------------------------------
// button_debounce
//
// Purpose:
//   Conditions a raw, bouncing push-button level for the downstream gate
//   blocks: synchronises it to clk, accepts a new level only after it has
//   been seen on STABLE_CYCLES+1 consecutive synchronised samples, and
//   produces one-cycle rise/fall pulses on each accepted change.
//
//   Optional feature (compile-time macro LONG_PRESS_EN):
//     When defined, a hold counter runs while the debounced level is high
//     and long_press pulses once, LONG_CYCLES edges after the rise. When
//     undefined, no hold logic exists and long_press is tied to 0.
//
// Parameters:
//   STABLE_CYCLES  (>=1) samples beyond the first needed to accept a level
//   LONG_CYCLES    (>=1) cycles high before long_press fires
//
// Ports:
//   clk         input  1  system clock, rising edge
//   rst_n       input  1  synchronous, active-low reset
//   A           input  1  raw asynchronous button level
//   Y           output 1  debounced level (registered)
//   rise        output 1  one-cycle pulse when Y goes 0->1 (registered)
//   fall        output 1  one-cycle pulse when Y goes 1->0 (registered)
//   long_press  output 1  one-cycle pulse after a sustained press
//
// Handshake: none. All outputs are plain registered levels/pulses valid
// every cycle; there is no valid/ready flow control on this block.
// -----------------------------------------------------------------------------
module button_debounce
  import button_debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = 16,
  parameter int LONG_CYCLES   = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic A,
  output logic Y,
  output logic rise,
  output logic fall,
  output logic long_press
);

  localparam int CW = bd_clog2(STABLE_CYCLES + 1);
  localparam int HW = bd_clog2(LONG_CYCLES + 1);

  localparam logic [CW-1:0] STABLE_C = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  // ---------------------------------------------------------------------------
  // Input synchroniser: only s1 is allowed to reach the FSM.
  // ---------------------------------------------------------------------------
  logic s1;

  sync_2ff u_sync (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .d_i    (A),
    .q_o    (s1)
  );

  // ---------------------------------------------------------------------------
  // Debounce FSM with registered outputs.
  // cnt_q counts consecutive samples at the candidate level; the first
  // sample moves into CHECK_* with cnt=1, so acceptance needs
  // STABLE_CYCLES+1 agreeing samples in total. Any disagreeing sample
  // drops back to the previous IDLE state with no partial credit, and
  // cnt_q is cleared on every exit so it can never pass STABLE_CYCLES.
  // ---------------------------------------------------------------------------
  bd_state_e     state_q;
  logic [CW-1:0] cnt_q;
  logic          y_q;
  logic          rise_q;
  logic          fall_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE_LOW;
      cnt_q   <= '0;
      y_q     <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      // Edge pulses last exactly one cycle unless re-asserted below.
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      unique case (state_q)
        IDLE_LOW: begin
          if (s1) begin
            state_q <= CHECK_HIGH;
            cnt_q   <= CNT_ONE;
          end
        end
        CHECK_HIGH: begin
          if (!s1) begin
            state_q <= IDLE_LOW;
            cnt_q   <= '0;
          end else if (cnt_q == STABLE_C) begin
            state_q <= IDLE_HIGH;
            cnt_q   <= '0;
            y_q     <= 1'b1;
            rise_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        IDLE_HIGH: begin
          if (!s1) begin
            state_q <= CHECK_LOW;
            cnt_q   <= CNT_ONE;
          end
        end
        CHECK_LOW: begin
          if (s1) begin
            state_q <= IDLE_HIGH;
            cnt_q   <= '0;
          end else if (cnt_q == STABLE_C) begin
            state_q <= IDLE_LOW;
            cnt_q   <= '0;
            y_q     <= 1'b0;
            fall_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= IDLE_LOW;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign Y    = y_q;
  assign rise = rise_q;
  assign fall = fall_q;

  // ---------------------------------------------------------------------------
  // Long-press detection.
  // ---------------------------------------------------------------------------
`ifdef LONG_PRESS_EN
  localparam logic [HW-1:0] LONG_C     = HW'(LONG_CYCLES);
  localparam logic [HW-1:0] LONG_M1    = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_ONE   = HW'(1);

  logic [HW-1:0] hold_cnt_q;
  logic [HW-1:0] hold_cnt_d;
  logic          long_q;
  logic          long_d;
  logic          stay_high;

  // The counter advances only on edges where the FSM is in IDLE_HIGH and
  // remains there; every other edge (including entry into IDLE_HIGH from
  // a check state) leaves it at 0, so an aborted release restarts the
  // hold time from scratch.
  assign stay_high = (state_q == IDLE_HIGH) && s1;

  always_comb begin
    hold_cnt_d = '0;
    long_d     = 1'b0;
    if (stay_high) begin
      if (hold_cnt_q == LONG_C) begin
        // Saturate: one pulse per press.
        hold_cnt_d = hold_cnt_q;
      end else begin
        hold_cnt_d = hold_cnt_q + HOLD_ONE;
        long_d     = (hold_cnt_q == LONG_M1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_cnt_q <= '0;
      long_q     <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      long_q     <= long_d;
    end
  end

  assign long_press = long_q;
`else
  // Feature not built; keep the parameter referenced so the sizing stays
  // consistent between both builds.
  logic [HW-1:0] unused_long_cfg;
  assign unused_long_cfg = HW'(LONG_CYCLES);
  assign long_press      = 1'b0;
`endif

endmodule : button_debounce
